// File: rtl/gemm_tile_ctrl_if.sv
// Command, SRAM-read and array-control bundle of the GEMM tile sequencer.
// master drives the command side; slave is the sequencer.
interface gemm_tile_ctrl_if #(
    parameter int M_WIDTH    = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  start;
    logic                  abort;
    logic [M_WIDTH-1:0]    cfg_m;
    logic [ADDR_WIDTH-1:0] cfg_w_base;
    logic [ADDR_WIDTH-1:0] cfg_a_base;
    logic                  busy;
    logic                  done;
    logic                  w_rd_en;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  a_rd_en;
    logic [ADDR_WIDTH-1:0] a_rd_addr;
    logic                  arr_clr;
    logic                  arr_load_weight;
    logic                  arr_en;
    logic                  res_valid;
    logic [M_WIDTH-1:0]    res_row_idx;

    modport master (
        output start, abort, cfg_m, cfg_w_base, cfg_a_base,
        input  busy, done, w_rd_en, w_rd_addr, a_rd_en, a_rd_addr,
        input  arr_clr, arr_load_weight, arr_en, res_valid, res_row_idx
    );

    modport slave (
        input  start, abort, cfg_m, cfg_w_base, cfg_a_base,
        output busy, done, w_rd_en, w_rd_addr, a_rd_en, a_rd_addr,
        output arr_clr, arr_load_weight, arr_en, res_valid, res_row_idx
    );
endinterface

// File: rtl/gemm_tile_ctrl.sv
// Weight-stationary GEMM tile sequencer: load weights, stream
// activations, tag result rows as they leave the systolic array.
module gemm_tile_ctrl #(
    parameter int ARRAY_N    = 16,
    parameter int M_WIDTH    = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int RES_LAT    = 2 * ARRAY_N
) (
    input logic             clk,
    input logic             rst_n,
    gemm_tile_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, LOAD_W, COMPUTE, DRAIN, DONE
    } state_t;

    localparam logic [M_WIDTH-1:0]    LAST_W = M_WIDTH'(ARRAY_N - 1);
    localparam logic [ADDR_WIDTH-1:0] W_OFF  = ADDR_WIDTH'(ARRAY_N - 1);

    state_t                state, state_n;
    logic [M_WIDTH-1:0]    cnt, cnt_n;
    logic [M_WIDTH-1:0]    m_q;
    logic [M_WIDTH-1:0]    idx;
    logic [ADDR_WIDTH-1:0] a_base_q;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic                  busy_q, busy_n;
    logic                  done_q, done_n;
    logic                  w_en, w_en_n;
    logic                  a_en, a_en_n;
    logic                  clr, clr_n;
    logic                  ld;
    logic                  acc;
    logic [RES_LAT-1:0]    lat;
    logic                  accept;
    logic                  last_res;

    assign accept   = (state == IDLE) && bus.start && !bus.abort;
    assign last_res = lat[RES_LAT-1] && (idx == m_q - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        w_en_n  = 1'b0;
        a_en_n  = 1'b0;
        clr_n   = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = LOAD_W;
                    cnt_n   = '0;
                    w_en_n  = 1'b1;
                    clr_n   = 1'b1;
                end
            end
            LOAD_W: begin
                if (cnt == LAST_W) begin
                    cnt_n = '0;
                    // m=0 still needs one more cycle for the last weight shift
                    if (m_q == '0) begin
                        state_n = DRAIN;
                    end else begin
                        state_n = COMPUTE;
                        a_en_n  = 1'b1;
                    end
                end else begin
                    cnt_n  = cnt + 1'b1;
                    w_en_n = 1'b1;
                end
            end
            COMPUTE: begin
                if (cnt == m_q - 1'b1) begin
                    state_n = DRAIN;
                end else begin
                    cnt_n  = cnt + 1'b1;
                    a_en_n = 1'b1;
                end
            end
            DRAIN: begin
                if (m_q == '0 || last_res) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (bus.abort) begin
            state_n = IDLE;
            w_en_n  = 1'b0;
            a_en_n  = 1'b0;
            clr_n   = 1'b0;
            done_n  = 1'b0;
        end
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            w_en     <= 1'b0;
            a_en     <= 1'b0;
            clr      <= 1'b0;
            ld       <= 1'b0;
            acc      <= 1'b0;
            lat      <= '0;
            m_q      <= '0;
            a_base_q <= '0;
            w_addr   <= '0;
            a_addr   <= '0;
            idx      <= '0;
        end else begin
            busy_q <= busy_n;
            done_q <= done_n;
            w_en   <= w_en_n;
            a_en   <= a_en_n;
            clr    <= clr_n;
            ld     <= w_en && !bus.abort;
            acc    <= a_en && !bus.abort;
            // arr_en delayed by the array latency marks each result row
            lat    <= bus.abort ? '0 : {lat[RES_LAT-2:0], acc};
            if (accept) begin
                m_q      <= bus.cfg_m;
                a_base_q <= bus.cfg_a_base;
                w_addr   <= bus.cfg_w_base + W_OFF;
            end else if (state == LOAD_W) begin
                w_addr <= w_addr - 1'b1;
            end
            if (state == LOAD_W) begin
                a_addr <= a_base_q;
            end else if (state == COMPUTE) begin
                a_addr <= a_addr + 1'b1;
            end
            if (accept || bus.abort) begin
                idx <= '0;
            end else if (lat[RES_LAT-1]) begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.w_rd_en         = w_en;
    assign bus.w_rd_addr       = w_addr;
    assign bus.a_rd_en         = a_en;
    assign bus.a_rd_addr       = a_addr;
    assign bus.arr_clr         = clr;
    assign bus.arr_load_weight = ld;
    assign bus.arr_en          = acc;
    assign bus.res_valid       = lat[RES_LAT-1];
    assign bus.res_row_idx     = idx;
endmodule

// File: tb/tb_gemm_tile_ctrl.sv
// Bench for gemm_tile_ctrl: tile table run back-to-back, address and
// row-index scoreboard, plus abort and async-reset sequences.
module tb_gemm_tile_ctrl;
    localparam int N  = 4;
    localparam int RL = 8;
    localparam int AW = 8;
    localparam int MW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    gemm_tile_ctrl_if #(.M_WIDTH(MW), .ADDR_WIDTH(AW)) bus ();

    gemm_tile_ctrl #(
        .ARRAY_N(N),
        .M_WIDTH(MW),
        .ADDR_WIDTH(AW),
        .RES_LAT(RL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        int m;
        int wb;
        int ab;
        int abort_at;
        int dup_at;
        int exp_done;
    } vec_t;

    vec_t tbl[6];
    int   wq[$];
    int   aq[$];
    int   rq[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   done_cyc;

    logic [7:0] obs;
    assign obs = {bus.busy, bus.done, bus.w_rd_en, bus.arr_clr,
                  bus.arr_load_weight, bus.a_rd_en, bus.arr_en,
                  bus.res_valid};

    task automatic chk(input string nm, input int c,
                       input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h",
                     nm, c, got, exp);
        end
    endtask

    // Strobe pattern from the documented cycle windows, start at cycle 0
    function automatic logic [7:0] exp_vec(input int c, input int m,
                                           input int d, input int ab);
        logic [7:0] v;
        if (c == 0 || (ab > 0 && c > ab)) return 8'h00;
        v[7] = (c >= 1 && c <= d);
        v[6] = (c == d);
        v[5] = (c >= 1 && c <= N);
        v[4] = (c == 1);
        v[3] = (c >= 2 && c <= N + 1);
        v[2] = (c >= N + 1 && c <= N + m);
        v[1] = (c >= N + 2 && c <= N + m + 1);
        v[0] = (c >= N + 2 + RL && c <= N + 1 + RL + m);
        return v;
    endfunction

    task automatic push(input int m, input int wb, input int ab);
        for (int i = 0; i < N; i++) wq.push_back((wb + N - 1 - i) & 8'hFF);
        for (int j = 0; j < m; j++) begin
            aq.push_back((ab + j) & 8'hFF);
            rq.push_back(j);
        end
    endtask

    task automatic flush();
        wq.delete();
        aq.delete();
        rq.delete();
    endtask

    task automatic sample(input int c, input int m,
                          input int d, input int ab);
        int e;
        chk("strobes", c, int'(obs), int'(exp_vec(c, m, d, ab)));
        if (bus.w_rd_en) begin
            chk("w_pending", c, int'(wq.size() > 0), 1);
            if (wq.size() > 0) begin
                e = wq.pop_front();
                chk("w_rd_addr", c, int'(bus.w_rd_addr), e);
            end
        end
        if (bus.a_rd_en) begin
            chk("a_pending", c, int'(aq.size() > 0), 1);
            if (aq.size() > 0) begin
                e = aq.pop_front();
                chk("a_rd_addr", c, int'(bus.a_rd_addr), e);
            end
        end
        if (bus.res_valid) begin
            chk("r_pending", c, int'(rq.size() > 0), 1);
            if (rq.size() > 0) begin
                e = rq.pop_front();
                chk("res_row_idx", c, int'(bus.res_row_idx), e);
            end
        end
        if (bus.done) done_cyc = c;
    endtask

    task automatic run(input vec_t v);
        int d;
        int last;
        d = (v.m == 0) ? N + 2 : N + 2 + RL + v.m;
        last = (v.abort_at > 0) ? 20 : d;
        done_cyc = 0;
        @(negedge clk);
        sample(0, v.m, d, v.abort_at);
        bus.start      = 1'b1;
        bus.cfg_m      = MW'(v.m);
        bus.cfg_w_base = AW'(v.wb);
        bus.cfg_a_base = AW'(v.ab);
        push(v.m, v.wb, v.ab);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            bus.start      = 1'b0;
            bus.abort      = 1'b0;
            bus.cfg_m      = 8'hA5;
            bus.cfg_w_base = 8'h5A;
            bus.cfg_a_base = 8'hC3;
            sample(c, v.m, d, v.abort_at);
            if (c == v.abort_at) begin
                bus.abort = 1'b1;
                flush();
            end
            if (c == v.dup_at) begin
                bus.start = 1'b1;
                bus.cfg_m = 8'd7;
            end
        end
        chk("done_cycle", last, done_cyc, v.exp_done);
        chk("sb_drained", last, wq.size() + aq.size() + rq.size(), 0);
    endtask

    initial begin
        tbl[0] = '{3, 'h10, 'h40, 0, 10, 17};
        tbl[1] = '{0, 'h20, 'h00, 0, 0, 6};
        tbl[2] = '{3, 'h10, 'h40, 7, 0, 0};
        tbl[3] = '{4, 'hFE, 'hFE, 0, 0, 18};
        tbl[4] = '{10, 'h30, 'h80, 0, 0, 24};
        tbl[5] = '{1, 'h00, 'h00, 0, 0, 15};

        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.cfg_m      = '0;
        bus.cfg_w_base = '0;
        bus.cfg_a_base = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", 0,
            int'({obs, bus.res_row_idx, bus.w_rd_addr, bus.a_rd_addr}), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run(tbl[i]);

        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.cfg_m = 8'd2;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.abort = 1'b0;
            chk("start_abort_idle", c, int'(obs), 0);
        end

        @(negedge clk);
        done_cyc = 0;
        bus.start      = 1'b1;
        bus.cfg_m      = 8'd3;
        bus.cfg_w_base = 8'h20;
        bus.cfg_a_base = 8'h50;
        push(3, 'h20, 'h50);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            sample(c, 3, N + 2 + RL + 3, 0);
        end
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst", 15, int'({obs, bus.res_row_idx}), 0);
        flush();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            chk("post_rst_quiet", c, int'(obs), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
